// File: rtl/allocator_pkg.sv
// Shared types for the allocator cores and the LSU sharing logic:
// request/response headers, LSU opcodes and the arbiter state encoding.
package allocator_pkg;

  localparam int unsigned HDR_ADDR_W = 32;
  localparam int unsigned HDR_SIZE_W = 16;

  typedef enum logic [2:0] {
    LOCK   = 3'd0,
    UNLOCK = 3'd1,
    LOAD   = 3'd2,
    INSERT = 3'd3,
    DELETE = 3'd4
  } req_lsu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOCK_RSP,
    OWNED,
    WAIT_OP_RSP,
    WAIT_UNLOCK_RSP
  } lsu_arb_state_e;

  typedef struct packed {
    logic [HDR_SIZE_W-1:0] size;
    logic [HDR_ADDR_W-1:0] addr;
  } header_data_t;

  typedef struct packed {
    header_data_t header_data;
    req_lsu_op_e  lsu_op;
    logic         val;
  } header_data_req_t;

  typedef struct packed {
    header_data_t header_data;
    logic         val;
  } header_data_rsp_t;

  function automatic logic is_lock(input header_data_req_t r);
    return r.val && (r.lsu_op == LOCK);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = 32'(ptr_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o           = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/lsu_arbiter.sv
// Lock-based sharing of one LSU between NUM_REQ allocator cores: a core must
// win a LOCK before its LOAD/INSERT/DELETE/UNLOCK traffic reaches the LSU.
module lsu_arbiter
  import allocator_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned LOCK_TIMEOUT = 1024,
  localparam int unsigned IW = $clog2(NUM_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  header_data_req_t req_i [NUM_REQ],
  output logic [NUM_REQ-1:0] ready_o,
  output header_data_rsp_t rsp_o [NUM_REQ],
  output header_data_req_t req_to_lsu_o,
  input  logic             lsu_ready_i,
  input  header_data_rsp_t rsp_from_lsu_i,
  output logic [IW-1:0]    owner_o,
  output logic             busy_o,
  output logic             err_o,
  output logic             timeout_o
);

  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

  lsu_arb_state_e state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  hold_q, hold_d;
  logic           err_q, err_d;
  logic           timeout_q, timeout_d;

  logic [NUM_REQ-1:0] lock_req;
  logic [NUM_REQ-1:0] rr_grant;
  logic [IW-1:0]      rr_idx;
  logic               rr_valid;
  logic               bad_idle;
  logic               spurious;
  logic               accept;
  header_data_req_t   own_req;

  always_comb begin
    lock_req = '0;
    bad_idle = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      lock_req[i] = is_lock(req_i[i]);
      if (req_i[i].val && (req_i[i].lsu_op != LOCK)) bad_idle = 1'b1;
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i   (lock_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (rr_grant),
    .idx_o   (rr_idx),
    .valid_o (rr_valid)
  );

  assign own_req  = req_i[owner_q];
  // A response where none is outstanding wins the cycle: it is dropped and
  // no request is accepted alongside it.
  assign spurious = rsp_from_lsu_i.val && ((state_q == IDLE) || (state_q == OWNED));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    err_d        = err_q;
    accept       = 1'b0;
    ready_o      = '0;
    req_to_lsu_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) rsp_o[i] = '0;

    if (spurious) err_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (bad_idle) err_d = 1'b1;
        if (!spurious && rr_valid) begin
          req_to_lsu_o = req_i[rr_idx];
          ready_o      = rr_grant & {NUM_REQ{lsu_ready_i}};
          if (lsu_ready_i) begin
            accept  = 1'b1;
            owner_d = rr_idx;
            state_d = WAIT_LOCK_RSP;
          end
        end
      end
      OWNED: begin
        if (is_lock(own_req)) err_d = 1'b1;
        else if (!spurious && own_req.val) begin
          req_to_lsu_o     = own_req;
          ready_o[owner_q] = lsu_ready_i;
          if (lsu_ready_i)
            state_d = (own_req.lsu_op == UNLOCK) ? WAIT_UNLOCK_RSP : WAIT_OP_RSP;
        end
      end
      WAIT_LOCK_RSP, WAIT_OP_RSP: begin
        rsp_o[owner_q] = rsp_from_lsu_i;
        if (rsp_from_lsu_i.val) state_d = OWNED;
      end
      WAIT_UNLOCK_RSP: begin
        rsp_o[owner_q] = rsp_from_lsu_i;
        if (rsp_from_lsu_i.val) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst_i) begin
      ready_o      = '0;
      req_to_lsu_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) rsp_o[i] = '0;
    end
  end

  always_comb begin
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      if (accept) hold_d = '0;
    end else begin
      if (hold_q != CW'(LOCK_TIMEOUT)) hold_d = hold_q + CW'(1);
      timeout_d = (hold_q == CW'(LOCK_TIMEOUT - 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      hold_q    <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      hold_q    <= hold_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
    end
  end

  assign owner_o   = owner_q;
  assign busy_o    = (state_q != IDLE);
  assign err_o     = err_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed lock/stall/error/timeout/reset scenarios,
// then random cores and LSU, all checked against a lock-ownership model.
module tb_lsu_arbiter;
  import allocator_pkg::*;

  localparam int N = 3;
  localparam int T = 8;

  logic             clk = 1'b0;
  logic             rst;
  header_data_req_t req [N];
  logic [N-1:0]     ready;
  header_data_rsp_t rsp [N];
  header_data_req_t fwd;
  logic             lsu_ready;
  header_data_rsp_t lrsp;
  logic [1:0]       owner;
  logic             busy, err, tmo;

  lsu_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(T)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .ready_o(ready), .rsp_o(rsp),
    .req_to_lsu_o(fwd), .lsu_ready_i(lsu_ready), .rsp_from_lsu_i(lrsp),
    .owner_o(owner), .busy_o(busy), .err_o(err), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who holds the lock, whether an LSU response is owed, and when
  // the current lock was taken / released (for the timeout pulse).
  bit m_held, m_wait, m_err;
  int m_owner, m_kind, m_next;
  int m_lock_cyc = -1000, m_rel_cyc = 0, cyc_n = 0;
  logic [N-1:0]     e_ready;
  header_data_req_t e_fwd;
  header_data_rsp_t e_rsp [N];
  bit               e_acc;

  task automatic evaluate();
    int w, c;
    bit spur, exp_t;
    w = -1; e_ready = '0; e_fwd = '0; e_acc = 0;
    for (int i = 0; i < N; i++) e_rsp[i] = '0;
    spur = lrsp.val && !(m_held && m_wait);
    if (!rst) begin
      if (!m_held) begin
        for (int k = 0; k < N; k++) begin
          c = (m_next + k) % N;
          if (w < 0 && req[c].val && req[c].lsu_op == LOCK) w = c;
        end
        if (!spur && w >= 0) begin
          e_fwd = req[w]; e_ready[w] = lsu_ready; e_acc = lsu_ready;
        end
      end else if (m_wait) begin
        e_rsp[m_owner] = lrsp;
      end else if (!spur && req[m_owner].val && req[m_owner].lsu_op != LOCK) begin
        e_fwd = req[m_owner]; e_ready[m_owner] = lsu_ready; e_acc = lsu_ready;
      end
    end
    exp_t = (cyc_n == m_lock_cyc + T + 1) && (m_rel_cyc >= m_lock_cyc + T);

    chk("ready_o", ready, e_ready);
    chk("req_to_lsu_o", fwd, e_fwd);
    for (int i = 0; i < N; i++) chk($sformatf("rsp_o[%0d]", i), rsp[i], e_rsp[i]);
    chk("busy_o", busy, m_held);
    if (m_held) chk("owner_o", owner, m_owner);
    chk("err_o", err, m_err);
    chk("timeout_o", tmo, exp_t);

    if (rst) begin
      m_held = 0; m_wait = 0; m_err = 0; m_owner = 0; m_next = 0; m_lock_cyc = -1000;
    end else begin
      if (spur) m_err = 1;
      if (!m_held)
        for (int i = 0; i < N; i++) if (req[i].val && req[i].lsu_op != LOCK) m_err = 1;
      if (m_held && !m_wait && req[m_owner].val && req[m_owner].lsu_op == LOCK) m_err = 1;
      if (!m_held) begin
        if (e_acc) begin
          m_held = 1; m_wait = 1; m_kind = 0; m_owner = w;
          m_lock_cyc = cyc_n; m_rel_cyc = 1 << 30;
        end
      end else if (m_wait) begin
        if (lrsp.val) begin
          m_wait = 0;
          if (m_kind == 2) begin
            m_held = 0; m_next = (m_owner + 1) % N; m_rel_cyc = cyc_n;
          end
        end
      end else if (e_acc) begin
        m_wait = 1; m_kind = (req[m_owner].lsu_op == UNLOCK) ? 2 : 1;
      end
    end
    cyc_n++;
  endtask

  task automatic settle();  @(negedge clk); endtask
  task automatic advance(); @(posedge clk); #1; endtask
  task automatic tick();    settle(); evaluate(); advance(); endtask

  task automatic set_req(input int c, input req_lsu_op_e op, input logic [31:0] addr);
    req[c] = '0; req[c].val = 1'b1; req[c].lsu_op = op; req[c].header_data.addr = addr;
  endtask

  // Issue one request from core c, wait for accept, answer after dly cycles.
  task automatic xact(input int c, input req_lsu_op_e op, input logic [31:0] addr, input int dly);
    bit got = 0;
    set_req(c, op, addr);
    for (int k = 0; k < 20 && !got; k++) begin
      settle(); evaluate(); got = e_ready[c]; advance();
    end
    req[c] = '0;
    if (!got) chk("xact_accept", 0, 1);
    for (int k = 1; k < dly; k++) tick();
    lrsp = '0; lrsp.val = 1'b1; lrsp.header_data.addr = addr;
    tick();
    lrsp = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int ph [N], cnt [N], nops [N];
  bit last_unlock [N];
  header_data_req_t nxt [N];
  header_data_rsp_t n_rsp;
  bit lsu_pend, draining, quiet, n_ready;
  int lsu_dly, pulses;
  logic [31:0] lsu_addr;

  initial begin
    rst = 1'b1; lsu_ready = 1'b1; lrsp = '0;
    for (int i = 0; i < N; i++) req[i] = '0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_busy", busy, 0); chk("rst_err", err, 0);
    chk("rst_owner", owner, 0); chk("rst_timeout", tmo, 0);
    evaluate(); advance();

    // Simultaneous LOCK from cores 0 and 1: core 0 first, core 1 after UNLOCK.
    set_req(0, LOCK, 0); set_req(1, LOCK, 0);
    settle(); chk("a_grant0", ready, 3'b001); evaluate(); advance();
    req[0] = '0;
    settle(); chk("a_owner0", owner, 0); chk("a_stall1", ready, 3'b000); evaluate(); advance();
    lrsp.val = 1'b1; tick(); lrsp = '0;
    xact(0, UNLOCK, 0, 2);
    settle(); chk("a_grant1", ready, 3'b010); evaluate(); advance();
    req[1] = '0;
    lrsp.val = 1'b1; tick(); lrsp = '0;

    // Core 1 LOAD 'h10 answered after 3 cycles; core 0 INSERT stalled.
    set_req(1, LOAD, 32'h10); set_req(0, INSERT, 32'h99);
    settle();
    chk("b_fwd_op", fwd.lsu_op, LOAD); chk("b_fwd_addr", fwd.header_data.addr, 32'h10);
    chk("b_ready1", ready, 3'b010);
    evaluate(); advance();
    req[1] = '0;
    for (int k = 0; k < 2; k++) begin
      settle(); chk("b_stall0", ready[0], 0); evaluate(); advance();
    end
    lrsp = '0; lrsp.val = 1'b1; lrsp.header_data.size = 16'h40; lrsp.header_data.addr = 32'h10;
    settle();
    chk("b_rsp1_val", rsp[1].val, 1); chk("b_rsp1_size", rsp[1].header_data.size, 16'h40);
    chk("b_rsp0_val", rsp[0].val, 0);
    evaluate(); advance();
    lrsp = '0;
    settle(); chk("b_owned", busy, 1); chk("b_no_insert", fwd.val, 0); evaluate(); advance();
    set_req(1, UNLOCK, 0);
    settle(); chk("b_unlock_fwd", fwd.lsu_op, UNLOCK); evaluate(); advance();
    req[1] = '0;
    settle(); chk("b_stall0_u", ready[0], 0); chk("b_no_insert_u", fwd.val, 0); evaluate(); advance();
    lrsp.val = 1'b1; set_req(0, LOCK, 0);
    tick();
    lrsp = '0;
    settle(); chk("b_lock0", fwd.lsu_op, LOCK); chk("b_ready0", ready, 3'b001); evaluate(); advance();
    req[0] = '0;
    lrsp.val = 1'b1; tick(); lrsp = '0;
    xact(0, INSERT, 32'h99, 2);
    xact(0, UNLOCK, 0, 1);

    // Timeout: core 2 holds the lock 20 cycles, one pulse 8 cycles after accept.
    set_req(2, LOCK, 0);
    settle(); chk("d_grant2", ready, 3'b100); evaluate(); advance();
    req[2] = '0;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      lrsp = '0; lrsp.val = (k == 2);
      settle();
      if (tmo) pulses++;
      if (k == 9) chk("d_tmo_at_8", tmo, 1);
      evaluate(); advance();
    end
    lrsp = '0;
    settle();
    chk("d_pulses", pulses, 1); chk("d_busy", busy, 1); chk("d_owner", owner, 2);
    evaluate(); advance();
    xact(2, UNLOCK, 0, 1);

    // DELETE in IDLE: dropped, sticky error.
    set_req(0, DELETE, 32'h5);
    settle(); chk("c_no_fwd", fwd.val, 0); chk("c_no_ready", ready, 3'b000); evaluate(); advance();
    settle(); chk("c_err", err, 1); evaluate(); advance();
    req[0] = '0;
    repeat (5) tick();
    settle(); chk("c_err_sticky", err, 1); evaluate(); advance();

    // Reset while an op response is owed; core 1 wins straight after.
    xact(0, LOCK, 0, 1);
    set_req(0, LOAD, 32'h20); tick(); req[0] = '0;
    tick();
    rst = 1'b1; set_req(1, LOCK, 0);
    tick();
    rst = 1'b0;
    settle();
    chk("e_busy", busy, 0); chk("e_err", err, 0); chk("e_grant1", ready, 3'b010);
    evaluate(); advance();
    req[1] = '0;
    lrsp.val = 1'b1; tick(); lrsp = '0;
    xact(1, UNLOCK, 0, 1);

    // Response with nothing outstanding.
    lrsp.val = 1'b1; tick(); lrsp = '0;
    settle(); chk("f_spurious_err", err, 1); evaluate(); advance();

    // Random cores and LSU.
    for (int i = 0; i < N; i++) begin
      ph[i] = 0; cnt[i] = $urandom_range(0, 4); last_unlock[i] = 0;
    end
    lsu_pend = 0; draining = 0; quiet = 0;
    for (int cy = 0; cy < 3000 && !quiet; cy++) begin
      if (cy >= 2500) draining = 1;
      settle(); evaluate();
      for (int i = 0; i < N; i++) begin
        nxt[i] = req[i];
        case (ph[i])
          0: if (cnt[i] > 0) cnt[i]--;
             else if (!draining) begin
               nxt[i] = '0; nxt[i].val = 1'b1; nxt[i].lsu_op = LOCK; ph[i] = 1;
             end
          1, 3: if (e_ready[i]) begin nxt[i] = '0; ph[i]++; end
          default: if (e_rsp[i].val) begin
            if (ph[i] == 2) nops[i] = $urandom_range(0, 3);
            if (ph[i] == 4 && last_unlock[i]) begin
              ph[i] = 0; cnt[i] = $urandom_range(0, 6);
            end else begin
              nxt[i] = '0; nxt[i].val = 1'b1;
              nxt[i].header_data.addr = $urandom;
              if (nops[i] == 0) begin
                nxt[i].lsu_op = UNLOCK; last_unlock[i] = 1;
              end else begin
                nxt[i].lsu_op = req_lsu_op_e'($urandom_range(2, 4));
                nops[i]--; last_unlock[i] = 0;
              end
              ph[i] = 3;
            end
          end
        endcase
      end
      n_rsp = '0;
      if (e_acc) begin
        lsu_pend = 1; lsu_dly = $urandom_range(0, 3); lsu_addr = e_fwd.header_data.addr;
      end else if (lsu_pend) begin
        if (lsu_dly == 0) begin
          n_rsp.val = 1'b1; n_rsp.header_data.addr = lsu_addr;
          n_rsp.header_data.size = 16'($urandom); lsu_pend = 0;
        end else lsu_dly--;
      end
      n_ready = ($urandom_range(0, 3) != 0);
      quiet = draining && !m_held && !lsu_pend;
      for (int i = 0; i < N; i++) if (ph[i] != 0) quiet = 0;
      advance();
      for (int i = 0; i < N; i++) req[i] = nxt[i];
      lrsp = n_rsp; lsu_ready = n_ready;
    end
    chk("drain_quiet", quiet, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of allocator cores sharing one LSU (2..8).
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 1024, owner lock-hold cycles before timeout flag.
REQ-003 SHALL have port clk_i  input  1  clock; single clock domain.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_i  input  NUM_REQ x header_data_req_t  per-core LSU request (header_data, lsu_op, val).
REQ-006 SHALL have port ready_o  output  NUM_REQ  per-core accept strobe.
REQ-007 SHALL have port rsp_o  output  NUM_REQ x header_data_rsp_t  per-core routed LSU response.
REQ-008 SHALL have port req_to_lsu_o  output  header_data_req_t  forwarded request.
REQ-009 SHALL have port lsu_ready_i  input  1  LSU can accept a request this cycle.
REQ-010 SHALL have port rsp_from_lsu_i  input  header_data_rsp_t  LSU response.
REQ-011 SHALL have port owner_o  output  clog2(NUM_REQ)  current lock owner index; valid while busy_o=1.
REQ-012 SHALL have port busy_o  output  1  lock currently held or being acquired or released.
REQ-013 SHALL have port err_o  output  1  sticky protocol-error flag.
REQ-014 SHALL have port timeout_o  output  1  one-cycle pulse when hold count reaches LOCK_TIMEOUT.

Function
REQ-015 SHALL implement states IDLE, WAIT_LOCK_RSP, OWNED, WAIT_OP_RSP, WAIT_UNLOCK_RSP.
REQ-016 IDLE: SHALL select among cores with val=1 and lsu_op=LOCK, round-robin starting at rr_ptr; winner's request forwarded combinationally to req_to_lsu_o in the same cycle.
REQ-017 IDLE: ready_o[winner] = lsu_ready_i; all other ready_o = 0; on accept (val & lsu_ready_i), owner <= winner, go WAIT_LOCK_RSP.
REQ-018 WAIT_LOCK_RSP / WAIT_OP_RSP / WAIT_UNLOCK_RSP: SHALL forward nothing (req_to_lsu_o.val=0); all ready_o = 0.
REQ-019 Any wait state: rsp_o[owner] = rsp_from_lsu_i; rsp_o of non-owners SHALL have val=0 at all times.
REQ-020 WAIT_LOCK_RSP -> OWNED and WAIT_OP_RSP -> OWNED on rsp_from_lsu_i.val.
REQ-021 OWNED: SHALL forward only req_i[owner]; ready_o[owner] = lsu_ready_i; on accept of LOAD/INSERT/DELETE go WAIT_OP_RSP; on accept of UNLOCK go WAIT_UNLOCK_RSP.
REQ-022 WAIT_UNLOCK_RSP -> IDLE on rsp_from_lsu_i.val; rr_ptr <= (owner+1) mod NUM_REQ in that cycle.
REQ-023 At most one LSU request outstanding at any time.
REQ-024 Non-owner requests outside IDLE SHALL be stalled (ready_o=0), never dropped; the non-owner keeps val asserted.
REQ-025 IDLE with a non-LOCK request from any core: SHALL not forward it, set err_o, hold it stalled.
REQ-026 OWNED with owner issuing LOCK: SHALL not forward it, set err_o, stall it.
REQ-027 rsp_from_lsu_i.val in IDLE or OWNED: SHALL drop it and set err_o.
REQ-028 Hold counter: SHALL clear on entry to WAIT_LOCK_RSP, increment each cycle while not IDLE, and saturate at LOCK_TIMEOUT; timeout_o pulses once when it reaches LOCK_TIMEOUT; the lock is not revoked.
REQ-029 busy_o = (state != IDLE); owner_o is registered.
REQ-030 In a single cycle, both a forwarded request accept and a response SHALL not both be acted on; response handling has priority, and the request is accepted only in a state that permits it (REQ-016..021).

Reset
REQ-031 On rst_i=1 at a clock edge: state=IDLE, rr_ptr=0, owner=0, hold counter=0, err_o=0, timeout_o=0.
REQ-032 During and after reset: all ready_o=0 except per REQ-017, req_to_lsu_o='0, all rsp_o='0.
REQ-033 Reset mid-operation SHALL abandon the lock without issuing UNLOCK; the LSU is reset alongside.

Structure
REQ-034 The core-op / state enum lsu_arb_state_e and NUM_REQ-independent constants SHALL live in allocator_pkg; header_data_req_t, header_data_rsp_t and req_lsu_op_e SHALL be reused from it.
REQ-035 Round-robin selection SHALL be one sub-module rr_arbiter (req vector, ptr -> one-hot grant, index, valid); everything else is inline.

Verification
REQ-036 Cores 0 and 1 both assert LOCK in the same IDLE cycle after reset, lsu_ready_i=1 -> core 0 granted; core 1 is stalled until core 0's UNLOCK response, then granted next.
REQ-037 Core 1 holds the lock and issues LOAD at addr 'h10; the LSU returns size 'h40 after 3 cycles -> rsp_o[1].val=1 with size 'h40, rsp_o[0].val=0, state returns to OWNED.
REQ-038 Core 0 issues INSERT while core 1 owns the lock -> ready_o[0]=0 until core 1's UNLOCK completes; INSERT is never seen at the LSU before core 0 acquires the lock.
REQ-039 Core 0 issues DELETE in IDLE -> not forwarded, err_o=1 and stays 1 until rst_i.
REQ-040 With LOCK_TIMEOUT=8, the owner holds the lock for 20 cycles -> exactly one timeout_o pulse, 8 cycles after the LOCK accept; the lock is retained.
REQ-041 rst_i is asserted in WAIT_OP_RSP -> next cycle busy_o=0, err_o=0, and a new LOCK from core 1 is granted immediately.
